zero_detect_scheduler: RTL and testbench

//  Round-robin scheduler sharing one serial zero-detect Moore FSM among NREQ requesters.

---
 rtl/zd_pkg.sv | 23 ++
 rtl/zero_detect_core.sv | 39 +++
 rtl/zero_detect_scheduler.sv | 157 +++++++++++++++
 tb/tb_zero_detect_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zd_pkg.sv
// Shared constants for the zero-detect scheduler:
// detector state codes, controller state encoding and the hit-count width helper.
package zd_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_GRANT  = 3'd1,
        C_CLEAR  = 3'd2,
        C_SHIFT  = 3'd3,
        C_DRAIN  = 3'd4,
        C_RESULT = 3'd5
    } ctrl_t;

    function automatic int hcw(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/zero_detect_core.sv
// Serial 2-bit Moore zero-detect FSM with synchronous clear.
// Ports: clk, rst (async active-low), clr_i (sync, wins over x_i), x_i, state_o.
module zero_detect_core
    import zd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       x_i,
    output logic [1:0] state_o
);

    logic [1:0] state_q;
    logic [1:0] state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0: state_d = x_i ? S0 : S1;
            S1: state_d = x_i ? S2 : S3;
            S2: state_d = x_i ? S2 : S3;
            S3: state_d = x_i ? S3 : S0;
        endcase
        if (clr_i) begin
            state_d = S0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/zero_detect_scheduler.sv
// Round-robin scheduler feeding NREQ requester words through one shared detector.
// Ports: req_valid_i/req_data_i/req_ready_o, res_valid_o/res_ready_i/res_id_o/res_state_o/res_hits_o, busy_o.
module zero_detect_scheduler
    import zd_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ),
    parameter int HCW   = hcw(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [IDW-1:0]        res_id_o,
    output logic [1:0]            res_state_o,
    output logic [HCW-1:0]        res_hits_o,
    output logic                  busy_o
);

    ctrl_t            ctrl_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] sreg_q;
    logic [HCW-1:0]   bit_cnt_q;
    logic [HCW-1:0]   hits_q;
    logic             sample_en_q;
    logic             res_valid_q;
    logic [1:0]       res_state_q;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   rr_next;
    logic [WIDTH-1:0] gnt_word;
    logic             det_clr;
    logic [1:0]       det_state;

    // Scan from the highest offset down so the
    // smallest offset from rr_ptr_q wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                gnt_word = req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rr_next = (gnt_idx == IDW'(NREQ - 1)) ?
                     '0 : gnt_idx + 1'b1;

    // The ready pulse follows req_valid_i within the
    // grant cycle so a dropped request is never taken.
    always_comb begin
        req_ready_o = '0;
        if (ctrl_q == C_GRANT && gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign det_clr = (ctrl_q == C_CLEAR);

    zero_detect_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (det_clr),
        .x_i     (sreg_q[0]),
        .state_o (det_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q      <= C_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            hits_q      <= '0;
            sample_en_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_state_q <= S0;
        end else begin
            // Detector output lags its input by one
            // cycle, so sampling trails SHIFT by one.
            sample_en_q <= (ctrl_q == C_SHIFT);
            if (sample_en_q && det_state == S3 &&
                hits_q != HCW'(WIDTH)) begin
                hits_q <= hits_q + 1'b1;
            end
            unique case (ctrl_q)
                C_IDLE: begin
                    if (|req_valid_i) begin
                        ctrl_q <= C_GRANT;
                    end
                end
                C_GRANT: begin
                    if (gnt_found) begin
                        sreg_q   <= gnt_word;
                        id_q     <= gnt_idx;
                        rr_ptr_q <= rr_next;
                        ctrl_q   <= C_CLEAR;
                    end else begin
                        ctrl_q <= C_IDLE;
                    end
                end
                C_CLEAR: begin
                    hits_q    <= '0;
                    bit_cnt_q <= '0;
                    ctrl_q    <= C_SHIFT;
                end
                C_SHIFT: begin
                    sreg_q    <= sreg_q >> 1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == HCW'(WIDTH - 1)) begin
                        ctrl_q <= C_DRAIN;
                    end
                end
                C_DRAIN: begin
                    res_state_q <= det_state;
                    res_valid_q <= 1'b1;
                    ctrl_q      <= C_RESULT;
                end
                C_RESULT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        ctrl_q      <= C_IDLE;
                    end
                end
                default: ctrl_q <= C_IDLE;
            endcase
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_id_o    = id_q;
    assign res_state_o = res_state_q;
    assign res_hits_o  = hits_q;
    assign busy_o      = (ctrl_q != C_IDLE);

endmodule

// File: tb/tb_zero_detect_scheduler.sv
// Directed bench for zero_detect_scheduler: reset, detector results,
// round-robin order, back-pressure, mid-word reset and dropped grants.
module tb_zero_detect_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [1:0]  res_state;
    logic [3:0]  res_hits;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    zero_detect_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_id_o    (res_id),
        .res_state_o (res_state),
        .res_hits_o  (res_hits),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic [3:0] g, output int n);
        g = 4'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (req_ready != 4'b0) begin
                g = req_ready;
                break;
            end
        end
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (res_valid) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 4'b0;
        req_data = 32'h0;
        res_ready = 1'b1;
        #12;
        vectors++;
        if ({req_ready, res_valid, res_id, res_state,
             res_hits, busy} !== 14'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy=%b v=%b id=%0d st=%0d h=%0d busy=%b want all 0",
                     req_ready, res_valid, res_id, res_state, res_hits, busy);
        end
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || req_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_idle got busy=%b rdy=%b want 0 0", busy, req_ready);
        end
    endtask

    task automatic test_single(input logic [7:0] d,
                               input logic [1:0] es,
                               input logic [3:0] eh);
        logic [3:0] g;
        int n;
        int lat;
        req_data = {24'h0, d};
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #1;
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_grant d=%h got %b want 0001", d, g);
        end
        tick();
        req_valid = 4'b0;
        lat = 1;
        wait_result(n);
        lat += n;
        vectors++;
        if (lat != 11) begin
            miscompares++;
            $display("FAIL single_latency d=%h got %0d want 11", d, lat);
        end
        vectors++;
        if (res_id !== 2'd0 || res_state !== es || res_hits !== eh) begin
            miscompares++;
            $display("FAIL single_result d=%h got id=%0d st=%0d h=%0d want id=0 st=%0d h=%0d",
                     d, res_id, res_state, res_hits, es, eh);
        end
        tick();
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_accept d=%h got v=%b busy=%b want 0 0", d, res_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        logic [3:0] exp_rr [5];
        int n;
        int gap;
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_data = 32'h0;
        res_ready = 1'b1;
        req_valid = 4'b1000;
        #1;
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b1000) begin
            miscompares++;
            $display("FAIL rr_wrap got %b want 1000", g);
        end
        tick();
        req_valid = 4'b1111;
        gap = 1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, n);
            gap += n;
            vectors++;
            if (g !== exp_rr[i] || gap != 13) begin
                miscompares++;
                $display("FAIL rr_order[%0d] got %b gap=%0d want %b gap=13",
                         i, g, gap, exp_rr[i]);
            end
            gap = 0;
        end
        tick();
        req_valid = 4'b0010;
        gap = 1;
        wait_grant(g, n);
        gap += n;
        vectors++;
        if (g !== 4'b0010 || gap != 13) begin
            miscompares++;
            $display("FAIL rr_ptr2_setup got %b gap=%0d want 0010 gap=13", g, gap);
        end
        tick();
        req_valid = 4'b0011;
        gap = 1;
        wait_grant(g, n);
        gap += n;
        vectors++;
        if (g !== 4'b0001 || gap != 13) begin
            miscompares++;
            $display("FAIL rr_ptr2_first got %b gap=%0d want 0001 gap=13", g, gap);
        end
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b0010 || n != 13) begin
            miscompares++;
            $display("FAIL rr_ptr2_second got %b gap=%0d want 0010 gap=13", g, n);
        end
        tick();
        req_valid = 4'b0;
        wait_result(n);
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] g;
        int n;
        int lat;
        int bad;
        req_data = 32'h0;
        req_valid = 4'b0001;
        res_ready = 1'b0;
        #1;
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b0001) begin
            miscompares++;
            $display("FAIL bp_grant got %b want 0001", g);
        end
        tick();
        req_valid = 4'b0110;
        req_data = 32'h0000_FF00;
        lat = 1;
        wait_result(n);
        lat += n;
        vectors++;
        if (lat != 11) begin
            miscompares++;
            $display("FAIL bp_latency got %0d want 11", lat);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (res_valid !== 1'b1 || res_id !== 2'd0 ||
                res_state !== 2'd3 || res_hits !== 4'd3 ||
                req_ready !== 4'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got v=%b id=%0d st=%0d h=%0d rdy=%b want 1 0 3 3 0000",
                         i, res_valid, res_id, res_state, res_hits, req_ready);
            end
            tick();
        end
        res_ready = 1'b1;
        #1;
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b0010 || n != 2) begin
            miscompares++;
            $display("FAIL bp_next_grant got %b after %0d want 0010 after 2", g, n);
        end
        tick();
        req_valid = 4'b0100;
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b0100 || n != 12) begin
            miscompares++;
            $display("FAIL bp_third_grant got %b after %0d want 0100 after 12", g, n);
        end
        tick();
        req_valid = 4'b0;
        wait_result(n);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        int n;
        req_data = 32'h0;
        req_valid = 4'b0010;
        res_ready = 1'b1;
        #1;
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b0010) begin
            miscompares++;
            $display("FAIL rmid_grant got %b want 0010", g);
        end
        tick();
        req_valid = 4'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (busy !== 1'b1 || res_id !== 2'd1) begin
            miscompares++;
            $display("FAIL rmid_pre got busy=%b id=%0d want 1 1", busy, res_id);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({req_ready, res_valid, res_id, res_state,
             res_hits, busy} !== 14'b0) begin
            miscompares++;
            $display("FAIL rmid_async got rdy=%b v=%b id=%0d st=%0d h=%0d busy=%b want all 0",
                     req_ready, res_valid, res_id, res_state, res_hits, busy);
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rmid_abort[%0d] got v=%b busy=%b want 0 0", i, res_valid, busy);
            end
        end
        req_valid = 4'b1111;
        #1;
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b0001 || n != 1) begin
            miscompares++;
            $display("FAIL rmid_rrptr got %b after %0d want 0001 after 1", g, n);
        end
        tick();
        req_valid = 4'b0;
        wait_result(n);
        tick();
    endtask

    task automatic test_grant_drop();
        logic [3:0] g;
        int n;
        int lat;
        req_data = 32'h00FF_0000;
        req_valid = 4'b0100;
        res_ready = 1'b1;
        #1;
        tick();
        req_valid = 4'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_no_ready got rdy=%b busy=%b want 0000 1", req_ready, busy);
        end
        for (int i = 0; i < 13; i++) begin
            tick();
            vectors++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
                miscompares++;
                $display("FAIL drop_idle[%0d] got v=%b busy=%b rdy=%b want 0 0 0000",
                         i, res_valid, busy, req_ready);
            end
        end
        req_valid = 4'b0100;
        #1;
        wait_grant(g, n);
        vectors++;
        if (g !== 4'b0100 || n != 1) begin
            miscompares++;
            $display("FAIL drop_regrant got %b after %0d want 0100 after 1", g, n);
        end
        tick();
        req_valid = 4'b0;
        lat = 1;
        wait_result(n);
        lat += n;
        vectors++;
        if (lat != 11 || res_id !== 2'd2 || res_state !== 2'd0 || res_hits !== 4'd0) begin
            miscompares++;
            $display("FAIL drop_result got lat=%0d id=%0d st=%0d h=%0d want 11 2 0 0",
                     lat, res_id, res_state, res_hits);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single(8'h00, 2'd3, 4'd3);
        test_single(8'hFF, 2'd0, 4'd0);
        test_single(8'hFE, 2'd2, 4'd0);
        test_single(8'hAA, 2'd2, 4'd2);
        test_single(8'h55, 2'd1, 4'd2);
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_grant_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
